// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch front end: base codes,
// loader FSM states and the ASCII-to-base mapping.
package nw_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    typedef enum logic [2:0] {
        LOAD_REF    = 3'd0,
        DRAIN_REF   = 3'd1,
        LOAD_QUERY  = 3'd2,
        DRAIN_QUERY = 3'd3,
        PRESENT     = 3'd4
    } state_t;

    // Returns {valid, code}; unknown characters map to code A with valid low.
    function automatic logic [2:0] ascii_to_base(input logic [7:0] ch);
        logic [2:0] res;
        case (ch)
            8'h41, 8'h61: res = {1'b1, BASE_A};
            8'h43, 8'h63: res = {1'b1, BASE_C};
            8'h47, 8'h67: res = {1'b1, BASE_G};
            8'h54, 8'h74: res = {1'b1, BASE_T};
            default:      res = {1'b0, BASE_A};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/base_encoder.sv
// Combinational ASCII nucleotide encoder with an invalid-character flag.
module base_encoder
    import nw_pkg::*;
(
    input  logic [7:0] in_data,
    output logic [1:0] code,
    output logic       invalid
);

    logic [2:0] dec_s;

    // Decode the character through the shared mapping
    always_comb begin
        dec_s   = ascii_to_base(in_data);
        code    = dec_s[1:0];
        invalid = ~dec_s[2];
    end

endmodule

// File: rtl/seq_loader.sv
// Byte-serial loader that packs a reference and a query sequence into
// parallel 2-bit-per-base vectors and hands the frame off on valid/ready.
module seq_loader
    import nw_pkg::*;
#(
    parameter int REF_LEN    = 15,
    parameter int QUERY_LEN  = 10,
    parameter int BASE_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [REF_LEN*BASE_WIDTH-1:0]   ref_seq,
    output logic [QUERY_LEN*BASE_WIDTH-1:0] query_seq,
    output logic                            seq_valid,
    input  logic                            seq_ready,
    output logic                            err_char,
    output logic                            err_len
);

    localparam int RIW = $clog2(REF_LEN + 1);
    localparam int QIW = $clog2(QUERY_LEN + 1);

    state_t                          state_q, state_d;
    logic [REF_LEN*BASE_WIDTH-1:0]   ref_q, ref_d;
    logic [QUERY_LEN*BASE_WIDTH-1:0] query_q, query_d;
    logic [RIW-1:0]                  ref_idx_q, ref_idx_d;
    logic [QIW-1:0]                  query_idx_q, query_idx_d;
    logic                            seq_valid_q, seq_valid_d;
    logic                            err_char_q, err_char_d;
    logic                            err_len_q, err_len_d;

    logic [1:0] enc_code_s;
    logic       enc_invalid_s;
    logic       accept_s;

    base_encoder u_enc (
        .in_data (in_data),
        .code    (enc_code_s),
        .invalid (enc_invalid_s)
    );

    assign accept_s  = in_valid && in_ready;
    assign in_ready  = (state_q != PRESENT);
    assign ref_seq   = ref_q;
    assign query_seq = query_q;
    assign seq_valid = seq_valid_q;
    assign err_char  = err_char_q;
    assign err_len   = err_len_q;

    // Next-state, packing and error-flag logic
    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        query_d     = query_q;
        ref_idx_d   = ref_idx_q;
        query_idx_d = query_idx_q;
        err_char_d  = err_char_q;
        err_len_d   = err_len_q;
        case (state_q)
            LOAD_REF: begin
                if (accept_s) begin
                    ref_d[(REF_LEN-1-int'(ref_idx_q))*BASE_WIDTH +: BASE_WIDTH] = BASE_WIDTH'(enc_code_s);
                    ref_idx_d  = ref_idx_q + RIW'(1);
                    err_char_d = err_char_q | enc_invalid_s;
                    if (in_last) begin
                        state_d   = LOAD_QUERY;
                        err_len_d = err_len_q | (ref_idx_q != RIW'(REF_LEN - 1));
                    end else if (ref_idx_q == RIW'(REF_LEN - 1)) begin
                        state_d = DRAIN_REF;
                    end else begin
                        state_d = LOAD_REF;
                    end
                end else begin
                    state_d = LOAD_REF;
                end
            end
            DRAIN_REF: begin
                if (accept_s) begin
                    err_len_d = 1'b1;
                    state_d   = in_last ? LOAD_QUERY : DRAIN_REF;
                end else begin
                    state_d = DRAIN_REF;
                end
            end
            LOAD_QUERY: begin
                if (accept_s) begin
                    query_d[(QUERY_LEN-1-int'(query_idx_q))*BASE_WIDTH +: BASE_WIDTH] = BASE_WIDTH'(enc_code_s);
                    query_idx_d = query_idx_q + QIW'(1);
                    err_char_d  = err_char_q | enc_invalid_s;
                    if (in_last) begin
                        state_d   = PRESENT;
                        err_len_d = err_len_q | (query_idx_q != QIW'(QUERY_LEN - 1));
                    end else if (query_idx_q == QIW'(QUERY_LEN - 1)) begin
                        state_d = DRAIN_QUERY;
                    end else begin
                        state_d = LOAD_QUERY;
                    end
                end else begin
                    state_d = LOAD_QUERY;
                end
            end
            DRAIN_QUERY: begin
                if (accept_s) begin
                    err_len_d = 1'b1;
                    state_d   = in_last ? PRESENT : DRAIN_QUERY;
                end else begin
                    state_d = DRAIN_QUERY;
                end
            end
            PRESENT: begin
                // Handoff clears everything so the next frame starts from zero
                if (seq_valid_q && seq_ready) begin
                    state_d     = LOAD_REF;
                    ref_d       = {(REF_LEN*BASE_WIDTH){1'b0}};
                    query_d     = {(QUERY_LEN*BASE_WIDTH){1'b0}};
                    ref_idx_d   = {RIW{1'b0}};
                    query_idx_d = {QIW{1'b0}};
                    err_char_d  = 1'b0;
                    err_len_d   = 1'b0;
                end else begin
                    state_d = PRESENT;
                end
            end
            default: begin
                state_d = LOAD_REF;
            end
        endcase
        seq_valid_d = (state_d == PRESENT);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD_REF;
            ref_q       <= {(REF_LEN*BASE_WIDTH){1'b0}};
            query_q     <= {(QUERY_LEN*BASE_WIDTH){1'b0}};
            ref_idx_q   <= {RIW{1'b0}};
            query_idx_q <= {QIW{1'b0}};
            seq_valid_q <= 1'b0;
            err_char_q  <= 1'b0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ref_q       <= ref_d;
            query_q     <= query_d;
            ref_idx_q   <= ref_idx_d;
            query_idx_q <= query_idx_d;
            seq_valid_q <= seq_valid_d;
            err_char_q  <= err_char_d;
            err_len_q   <= err_len_d;
        end
    end

endmodule

// File: tb/tb_seq_loader.sv
// Randomised scoreboard bench for seq_loader: a driver pushes the expected
// frame from a string-level model, a monitor pops it at each handoff.
module tb_seq_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [29:0] ref_seq;
    logic [19:0] query_seq;
    logic        seq_valid;
    logic        seq_ready;
    logic        err_char;
    logic        err_len;

    int checks   = 0;
    int failures = 0;

    typedef byte bq_t[$];
    typedef struct {
        logic [29:0] r;
        logic [19:0] q;
        logic        ec;
        logic        el;
    } exp_t;

    exp_t sb[$];

    seq_loader dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .ref_seq   (ref_seq),
        .query_seq (query_seq),
        .seq_valid (seq_valid),
        .seq_ready (seq_ready),
        .err_char  (err_char),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int base_code(input byte c);
        case (c)
            "A", "a": return 0;
            "C", "c": return 1;
            "G", "g": return 2;
            "T", "t": return 3;
            default:  return -1;
        endcase
    endfunction

    // Reference model: shift bases in from index 0, pad missing ones with A
    function automatic exp_t model(input bq_t r, input bq_t q);
        exp_t e;
        int   c;
        e.r  = '0;
        e.q  = '0;
        e.ec = 1'b0;
        e.el = (r.size() != 15) || (q.size() != 10);
        for (int k = 0; k < 15; k++) begin
            c = (k < r.size()) ? base_code(r[k]) : 0;
            if (c < 0) begin e.ec = 1'b1; c = 0; end
            e.r = {e.r[27:0], c[1:0]};
        end
        for (int k = 0; k < 10; k++) begin
            c = (k < q.size()) ? base_code(q[k]) : 0;
            if (c < 0) begin e.ec = 1'b1; c = 0; end
            e.q = {e.q[17:0], c[1:0]};
        end
        return e;
    endfunction

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic int gap_of(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(0, 2));
    endfunction

    task automatic send_char(input byte c, input bit last, input int gap);
        in_data  = c;
        in_valid = 1'b1;
        in_last  = last;
        check("in_ready_loading", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    endtask

    task automatic do_frame(input bq_t r, input bq_t q, input int mode, input int hold);
        exp_t e;
        e = model(r, q);
        for (int i = 0; i < r.size(); i++) send_char(r[i], i == r.size() - 1, gap_of(mode));
        for (int i = 0; i < q.size(); i++)
            send_char(q[i], i == q.size() - 1, (i == q.size() - 1) ? 0 : gap_of(mode));
        sb.push_back(e);
        check("seq_valid_latency", seq_valid, 1);
        for (int h = 0; h < hold; h++) begin @(posedge clk); #1; end
        check("seq_valid_held", seq_valid, 1);
        seq_ready = 1'b1;
        @(posedge clk); #1;
        seq_ready = 1'b0;
        check("post_handoff_valid", seq_valid, 0);
        check("post_handoff_in_ready", in_ready, 1);
        check("post_handoff_vectors", {ref_seq, query_seq}, 0);
        check("post_handoff_errs", {err_char, err_len}, 0);
    endtask

    // Monitor: compare frames at handoff and stability while stalled
    initial begin
        logic        hold_prev;
        logic [29:0] pr;
        logic [19:0] pq;
        logic [1:0]  pe;
        exp_t        e;
        hold_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (seq_valid === 1'b1) begin
                check("in_ready_present", in_ready, 0);
                if (hold_prev) begin
                    check("stall_stable_ref", ref_seq, pr);
                    check("stall_stable_query", query_seq, pq);
                    check("stall_stable_errs", {err_char, err_len}, pe);
                end
                if (seq_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: got a frame, expected none at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("frame_ref_seq", ref_seq, e.r);
                        check("frame_query_seq", query_seq, e.q);
                        check("frame_err_char", err_char, e.ec);
                        check("frame_err_len", err_len, e.el);
                    end
                end
                hold_prev = !seq_ready;
                pr = ref_seq;
                pq = query_seq;
                pe = {err_char, err_len};
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        string vs;
        string bad;
        bq_t   r;
        bq_t   q;
        int    rl;
        int    ql;
        vs  = "ACGTacgt";
        bad = "NX.z";

        rst       = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        seq_ready = 1'b0;
        #12;
        check("reset_in_ready", in_ready, 1);
        check("reset_vectors", {ref_seq, query_seq}, 0);
        check("reset_flags", {seq_valid, err_char, err_len}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        do_frame(s2q("ACGTACGTACGTACG"), s2q("ACGTACGTAC"), 0, 0);
        do_frame(s2q("acgtacgtacgtacg"), s2q("acgtacgtac"), 1, 0);
        do_frame(s2q("ACGTACGTACGTACG"), s2q("ACGTNCGTAC"), 0, 1);
        do_frame(s2q("ACGTACGTACGTACG"), s2q("ACGTACGT"), 0, 0);
        do_frame(s2q("ACGTACGTACGTACG"), s2q("ACGTACGTACGT"), 0, 0);
        do_frame(s2q("TTTTTGGGGGCCCCCAAA"), s2q("GATTACAGAT"), 2, 0);
        do_frame(s2q("GGGGCCCCAAAATTT"), s2q("TGCATGCATG"), 0, 5);
        do_frame(s2q("ACGTACGTACGTACG"), s2q("ACGTACGTAC"), 0, 0);

        // Reset in the middle of a reference sequence
        for (int i = 0; i < 7; i++) send_char("G", 1'b0, 0);
        rst = 1'b0;
        #1;
        check("midreset_in_ready", in_ready, 1);
        check("midreset_vectors", {ref_seq, query_seq}, 0);
        check("midreset_flags", {seq_valid, err_char, err_len}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        do_frame(s2q("CAGTCAGTCAGTCAG"), s2q("TTGGCCAATT"), 0, 0);

        for (int n = 0; n < 25; n++) begin
            r.delete();
            q.delete();
            rl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 18)) : 15;
            ql = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 13)) : 10;
            for (int k = 0; k < rl; k++)
                r.push_back((k < 15 && $urandom_range(0, 11) == 0) ? bad[$urandom_range(0, 3)] : vs[$urandom_range(0, 7)]);
            for (int k = 0; k < ql; k++)
                q.push_back((k < 10 && $urandom_range(0, 11) == 0) ? bad[$urandom_range(0, 3)] : vs[$urandom_range(0, 7)]);
            do_frame(r, q, 2, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
